// File: rtl/checkbits_seq_monitor.sv
// Ordered checkpoint monitor for a checkbits bus: masked markers, glitch filter, per-checkpoint timeout.
// Optional abort-marker detection is compiled in with `define CHKMON_ABORT_EN.
module checkbits_seq_monitor #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int HOLD  = 2,
    parameter int TMO_W = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           checkbits,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]           cfg_value,
    input  logic [WIDTH-1:0]           cfg_mask,
    input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
    input  logic [TMO_W-1:0]           timeout_limit,
    input  logic [WIDTH-1:0]           abort_value,
    input  logic                       start,
    output logic                       busy,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [TMO_W-1:0]           elapsed
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int SW = $clog2(HOLD+1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [SW-1:0] HOLD_S  = SW'(HOLD);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  sync1, sync2;
    logic [WIDTH-1:0]  tbl_value [DEPTH];
    logic [WIDTH-1:0]  tbl_mask  [DEPTH];
    logic [LW-1:0]     cur_idx, cur_idx_n, len_q, len_n;
    logic [SW-1:0]     stable, stable_n, astable, astable_n;
    logic [AW-1:0]     cur_a, hit_idx_n;
    logic [TMO_W-1:0]  elapsed_n;
    logic [1:0]        fail_code_n;
    logic              busy_n, hit_n, pass_n, fail_n;
    logic              done, match, hit_now, timeout_now, abort_match, abort_now, arm;

    // checkbits is asynchronous to clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= checkbits;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_value[i] <= '0;
                tbl_mask[i]  <= '0;
            end
        end else if (cfg_we && !busy) begin
            tbl_value[cfg_addr] <= cfg_value;
            tbl_mask[cfg_addr]  <= cfg_mask;
        end
    end

    assign cur_a       = cur_idx[AW-1:0];
    assign done        = (cur_idx >= len_q);
    assign match       = ((sync2 & tbl_mask[cur_a]) == (tbl_value[cur_a] & tbl_mask[cur_a]));
    assign hit_now     = (stable == HOLD_S);
    assign timeout_now = (timeout_limit != '0) && (elapsed == timeout_limit);
    assign arm         = start && (state != S_WAIT);

`ifdef CHKMON_ABORT_EN
    assign abort_match = (sync2 == abort_value);
    assign abort_now   = (astable == HOLD_S);
`else
    logic abort_unused;
    assign abort_unused = ^abort_value;
    assign abort_match  = 1'b0;
    assign abort_now    = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Priority in WAIT: abort over hit, hit over timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_PASS, S_FAIL: if (start) state_n = S_WAIT;
            S_WAIT: begin
                if (done)             state_n = S_PASS;
                else if (abort_now)   state_n = S_FAIL;
                else if (hit_now)     state_n = S_WAIT;
                else if (timeout_now) state_n = S_FAIL;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cur_idx_n   = cur_idx;
        len_n       = len_q;
        stable_n    = stable;
        astable_n   = astable;
        elapsed_n   = elapsed;
        busy_n      = busy;
        hit_n       = 1'b0;
        hit_idx_n   = hit_idx;
        pass_n      = pass;
        fail_n      = fail;
        fail_code_n = fail_code;
        if (arm) begin
            cur_idx_n   = '0;
            len_n       = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
            stable_n    = '0;
            astable_n   = '0;
            elapsed_n   = '0;
            busy_n      = 1'b1;
            pass_n      = 1'b0;
            fail_n      = 1'b0;
            fail_code_n = 2'b00;
        end else if (state == S_WAIT) begin
            astable_n = abort_match ? astable + 1'b1 : '0;
            if (done) begin
                pass_n = 1'b1;
                busy_n = 1'b0;
            end else if (abort_now) begin
                fail_n      = 1'b1;
                fail_code_n = 2'b10;
                busy_n      = 1'b0;
            end else if (hit_now) begin
                hit_n     = 1'b1;
                hit_idx_n = cur_a;
                cur_idx_n = cur_idx + 1'b1;
                stable_n  = '0;
                elapsed_n = '0;
            end else if (timeout_now) begin
                fail_n      = 1'b1;
                fail_code_n = 2'b01;
                busy_n      = 1'b0;
            end else begin
                stable_n  = match ? stable + 1'b1 : '0;
                elapsed_n = (&elapsed) ? elapsed : elapsed + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_idx   <= '0;
            len_q     <= '0;
            stable    <= '0;
            astable   <= '0;
            elapsed   <= '0;
            busy      <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'b00;
        end else begin
            cur_idx   <= cur_idx_n;
            len_q     <= len_n;
            stable    <= stable_n;
            astable   <= astable_n;
            elapsed   <= elapsed_n;
            busy      <= busy_n;
            hit       <= hit_n;
            hit_idx   <= hit_idx_n;
            pass      <= pass_n;
            fail      <= fail_n;
            fail_code <= fail_code_n;
        end
    end
endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Directed bench for checkbits_seq_monitor (default parameters, HOLD=2).
module tb_checkbits_seq_monitor;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] checkbits = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_value = '0, cfg_mask = '0;
    logic [3:0]  cfg_len = '0;
    logic [23:0] timeout_limit = '0;
    logic [15:0] abort_value = '0;
    logic        start = 1'b0;
    logic        busy, hit, pass, fail;
    logic [2:0]  hit_idx;
    logic [1:0]  fail_code;
    logic [23:0] elapsed;

    int checks = 0, errors = 0;
    logic [15:0] vals [6] = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB60};

    checkbits_seq_monitor dut (
        .clock(clock), .reset(reset), .checkbits(checkbits),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .timeout_limit(timeout_limit), .abort_value(abort_value),
        .start(start), .busy(busy), .hit(hit), .hit_idx(hit_idx), .pass(pass),
        .fail(fail), .fail_code(fail_code), .elapsed(elapsed)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 6; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_value = vals[i]; cfg_mask = 16'hFFFF;
            tick();
        end
        cfg_we  = 1'b0;
        cfg_len = 4'd6;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Hold v for n cycles; report hit count, cycle of first hit, last hit_idx, cycle pass first seen.
    task automatic drive_seg(input logic [15:0] v, input int n,
                             output int hits, output int first_hit, output int idx, output int pass_cyc);
        checkbits = v; hits = 0; first_hit = 0; idx = -1; pass_cyc = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (hit) begin
                hits++;
                if (first_hit == 0) first_hit = c;
                idx = int'(hit_idx);
            end
            if (pass && pass_cyc == 0) pass_cyc = c;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, hit, pass, fail, fail_code} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {busy, hit, pass, fail, fail_code});
        end
        checks++;
        if (elapsed !== 24'd0 || hit_idx !== 3'd0) begin
            errors++; $display("FAIL reset_counters: elapsed=%0d hit_idx=%0d want 0/0", elapsed, hit_idx);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_in_order();
        int h, f, x, p;
        load_table();
        timeout_limit = '0; checkbits = '0;
        arm();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        for (int i = 0; i < 6; i++) begin
            drive_seg(vals[i], 10, h, f, x, p);
            checks++;
            if (h != 1 || f != 5 || x != i) begin
                errors++; $display("FAIL in_order_hit%0d: hits=%0d at=%0d idx=%0d want 1/5/%0d", i, h, f, x, i);
            end
        end
        checks++;
        if (p != 6) begin errors++; $display("FAIL pass_latency: pass at cycle %0d want 6", p); end
        checks++;
        if ({pass, fail, fail_code, busy} !== 5'b10000) begin
            errors++; $display("FAIL in_order_result: pass/fail/code/busy=%b want 10000", {pass, fail, fail_code, busy});
        end
    endtask

    task automatic test_out_of_order();
        int h, f, x, p;
        arm();
        drive_seg(16'hAB40, 10, h, f, x, p);
        drive_seg(16'h0044, 10, h, f, x, p);
        checks++;
        if (h != 0) begin errors++; $display("FAIL early_marker: hits=%0d want 0", h); end
        drive_seg(16'h003E, 10, h, f, x, p);
        checks++;
        if (h != 1 || f != 5 || x != 1) begin
            errors++; $display("FAIL resume_idx1: hits=%0d at=%0d idx=%0d want 1/5/1", h, f, x);
        end
        for (int i = 2; i < 6; i++) drive_seg(vals[i], 10, h, f, x, p);
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL out_of_order_pass: pass=%b fail=%b want 1/0", pass, fail);
        end
    endtask

    task automatic test_glitch_and_busy();
        int h, f, x, p, h1, h2, f2, x2;
        arm();
        drive_seg(16'hAB40, 10, h, f, x, p);
        drive_seg(16'h003E, 1, h1, f, x, p);
        drive_seg(16'h0000, 9, h, f, x, p);
        h1 += h;
        checks++;
        if (h1 != 0) begin errors++; $display("FAIL glitch_1cyc: hits=%0d want 0", h1); end
        drive_seg(16'h003E, 2, h1, f, x, p);
        drive_seg(16'h0000, 8, h2, f2, x2, p);
        checks++;
        if (h1 != 0 || h2 != 1 || f2 != 3 || x2 != 1) begin
            errors++; $display("FAIL hold_2cyc: hits=%0d/%0d at=%0d idx=%0d want 0/1/3/1", h1, h2, f2, x2);
        end
        // table write and start while busy must both be ignored
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_value = 16'h1234; cfg_mask = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        arm();
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0) begin
            errors++; $display("FAIL start_while_busy: busy=%b pass=%b want 1/0", busy, pass);
        end
        drive_seg(16'h0044, 10, h, f, x, p);
        checks++;
        if (h != 1 || x != 2) begin errors++; $display("FAIL continue_idx2: hits=%0d idx=%0d want 1/2", h, x); end
        drive_seg(16'h004A, 10, h, f, x, p);
        checks++;
        if (h != 1 || x != 3) begin errors++; $display("FAIL write_while_busy: hits=%0d idx=%0d want 1/3", h, x); end
        drive_seg(16'h0050, 10, h, f, x, p);
        drive_seg(16'hAB60, 10, h, f, x, p);
        checks++;
        if (pass !== 1'b1) begin errors++; $display("FAIL glitch_seq_pass: pass=%b want 1", pass); end
    endtask

    task automatic test_timeout();
        int h, f, x, p, fk;
        logic [23:0] el50;
        timeout_limit = 24'd100; checkbits = '0;
        arm();
        drive_seg(16'hAB40, 5, h, f, x, p);
        checks++;
        if (h != 1 || f != 5) begin errors++; $display("FAIL timeout_idx0_hit: hits=%0d at=%0d want 1/5", h, f); end
        fk = 0; el50 = '0;
        for (int k = 1; k <= 150 && fk == 0; k++) begin
            tick();
            if (k == 50) el50 = elapsed;
            if (fail) fk = k;
        end
        checks++;
        if (fk != 101) begin errors++; $display("FAIL timeout_latency: fail at %0d want 101", fk); end
        checks++;
        if (el50 !== 24'd50) begin errors++; $display("FAIL elapsed_count: got %0d want 50", el50); end
        checks++;
        if (fail_code !== 2'b01 || busy !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL timeout_result: code=%b busy=%b pass=%b want 01/0/0", fail_code, busy, pass);
        end
        timeout_limit = '0;
        arm();
        checks++;
        if (fail !== 1'b0 || fail_code !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL rearm_after_fail: fail=%b code=%b busy=%b want 0/00/1", fail, fail_code, busy);
        end
    endtask

    task automatic test_abort();
        int h, f, x, p;
        abort_value = 16'hAB51;
        drive_seg(16'hAB40, 10, h, f, x, p);
        drive_seg(16'h003E, 10, h, f, x, p);
        drive_seg(16'hAB51, 10, h, f, x, p);
        checks++;
`ifdef CHKMON_ABORT_EN
        if (fail !== 1'b1 || fail_code !== 2'b10 || busy !== 1'b0) begin
            errors++; $display("FAIL abort: fail=%b code=%b busy=%b want 1/10/0", fail, fail_code, busy);
        end
`else
        if (fail !== 1'b0 || fail_code !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_disabled: fail=%b code=%b busy=%b want 0/00/1", fail, fail_code, busy);
        end
`endif
        abort_value = '0;
    endtask

    task automatic test_reset_mid();
        int h, f, x, p;
        reset = 1'b1; #2; reset = 1'b0;
        load_table();
        checkbits = '0;
        arm();
        drive_seg(16'hAB40, 10, h, f, x, p);
        drive_seg(16'h003E, 10, h, f, x, p);
        drive_seg(16'h0044, 10, h, f, x, p);
        checks++;
        if (busy !== 1'b1 || hit_idx !== 3'd2 || elapsed == 24'd0) begin
            errors++; $display("FAIL pre_reset_state: busy=%b hit_idx=%0d elapsed=%0d want 1/2/nonzero", busy, hit_idx, elapsed);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, hit, pass, fail, fail_code, hit_idx} !== 9'b0 || elapsed !== 24'd0) begin
            errors++; $display("FAIL async_reset: flags=%b elapsed=%0d want 0/0", {busy, hit, pass, fail, fail_code, hit_idx}, elapsed);
        end
        #1 reset = 1'b0;
        // cleared table: entry 0 has mask 0 and matches anything
        cfg_len = 4'd1;
        checkbits = 16'h5A5A;
        arm();
        drive_seg(16'h5A5A, 4, h, f, x, p);
        checks++;
        if (h != 1 || f != 3 || x != 0 || p != 4) begin
            errors++; $display("FAIL table_cleared: hits=%0d at=%0d idx=%0d pass_at=%0d want 1/3/0/4", h, f, x, p);
        end
    endtask

    task automatic test_len_zero();
        cfg_len = 4'd0; checkbits = '0;
        arm();
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0) begin
            errors++; $display("FAIL len0_start: busy=%b pass=%b want 1/0", busy, pass);
        end
        tick();
        checks++;
        if (pass !== 1'b1 || busy !== 1'b0 || hit !== 1'b0) begin
            errors++; $display("FAIL len0_pass: pass=%b busy=%b hit=%b want 1/0/0", pass, busy, hit);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_glitch_and_busy();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_len_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
